// File: rtl/codec_cfg_pkg.sv
// Shared types and the default register-write table for the codec configuration sequencer.
package codec_cfg_pkg;

  typedef enum logic [3:0] {
    PWR    = 4'd0,
    LOAD   = 4'd1,
    ISSUE  = 4'd2,
    WAIT_B = 4'd3,
    WAIT_D = 4'd4,
    CHECK  = 4'd5,
    GAP    = 4'd6,
    DONE   = 4'd7,
    FAIL   = 4'd8
  } cfg_state_t;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } cfg_entry_t;

  localparam int unsigned CFG_TABLE_LEN = 11;

  // Codec bring-up order: reset, power, format, sampling, input/output levels, activate.
  localparam cfg_entry_t CFG_INIT_TABLE [CFG_TABLE_LEN] = '{
    '{reg_addr: 8'h1E, data: 8'h00},
    '{reg_addr: 8'h0C, data: 8'h10},
    '{reg_addr: 8'h0E, data: 8'h02},
    '{reg_addr: 8'h10, data: 8'h00},
    '{reg_addr: 8'h00, data: 8'h17},
    '{reg_addr: 8'h02, data: 8'h17},
    '{reg_addr: 8'h04, data: 8'h79},
    '{reg_addr: 8'h06, data: 8'h79},
    '{reg_addr: 8'h08, data: 8'h12},
    '{reg_addr: 8'h0A, data: 8'h00},
    '{reg_addr: 8'h12, data: 8'h01}
  };

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/codec_cfg_rom.sv
// Combinational lookup of one configuration table entry; indices past the table read as zero.
module codec_cfg_rom
  import codec_cfg_pkg::*;
#(
  parameter int unsigned NUM_REGS = CFG_TABLE_LEN
) (
  input  logic [7:0] i_idx,
  output cfg_entry_t o_entry
);

  localparam int unsigned IW = $clog2(CFG_TABLE_LEN);

  logic [IW-1:0] w_sel;

  assign w_sel = i_idx[IW-1:0];

  // Table read guarded by both the configured entry count and the physical table size.
  always_comb begin
    o_entry = 16'h0000;
    if ((32'(i_idx) < NUM_REGS) && (32'(i_idx) < CFG_TABLE_LEN)) begin
      o_entry = CFG_INIT_TABLE[w_sel];
    end else begin
      o_entry = 16'h0000;
    end
  end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Power-up / reconfiguration sequencer: walks the codec register table and issues one I2C
// write per entry, retrying NACKed writes and reporting done or error.
module codec_cfg_sequencer
  import codec_cfg_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR     = 7'h1A,
  parameter int unsigned NUM_REGS     = 11,
  parameter int unsigned PWR_WAIT     = 50000,
  parameter int unsigned GAP_CYCLES   = 512,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned BUSY_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       reconfig,
  output logic       i2c_start,
  output logic [6:0] i2c_dev_addr,
  output logic [7:0] i2c_reg_addr,
  output logic [7:0] i2c_data,
  input  logic       i2c_busy,
  input  logic       i2c_ack_error,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_error,
  output logic [7:0] cfg_index
);

  localparam int unsigned CW = $clog2(max3(PWR_WAIT, GAP_CYCLES, BUSY_TIMEOUT) + 1);

  cfg_state_t  r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [7:0]  r_idx, w_idx_next;
  logic [2:0]  r_retry, w_retry_next;
  logic        r_nack, w_nack_next;
  logic        r_start, r_busy, r_done, r_error;
  logic [7:0]  r_reg_addr, r_data;
  cfg_entry_t  w_entry;

  // The ROM is addressed with the next index so the entry is already on the bus during LOAD.
  codec_cfg_rom #(.NUM_REGS(NUM_REGS)) u_rom (
    .i_idx   (w_idx_next),
    .o_entry (w_entry)
  );

  // Next-state, index/retry bookkeeping and NACK flag accumulation.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_retry_next = r_retry;
    w_nack_next  = r_nack;
    w_cnt_next   = r_cnt;
    case (r_state)
      PWR: begin
        if (r_cnt == CW'(PWR_WAIT - 1)) begin
          w_state_next = LOAD;
          w_idx_next   = 8'd0;
          w_retry_next = 3'd0;
        end else begin
          w_state_next = PWR;
        end
      end
      LOAD:  w_state_next = ISSUE;
      ISSUE: begin
        w_state_next = WAIT_B;
        w_nack_next  = 1'b0;
      end
      WAIT_B: begin
        if (i2c_busy) begin
          w_state_next = WAIT_D;
        end else if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
          // A controller that never starts is treated exactly like a NACK.
          w_state_next = CHECK;
          w_nack_next  = 1'b1;
        end else begin
          w_state_next = WAIT_B;
        end
      end
      WAIT_D: begin
        w_nack_next = r_nack | i2c_ack_error;
        if (!i2c_busy) begin
          w_state_next = CHECK;
        end else begin
          w_state_next = WAIT_D;
        end
      end
      CHECK: begin
        if (!r_nack) begin
          if (r_idx == 8'(NUM_REGS - 1)) begin
            w_state_next = DONE;
          end else begin
            w_state_next = GAP;
            w_idx_next   = r_idx + 8'd1;
            w_retry_next = 3'd0;
          end
        end else if (r_retry < 3'(MAX_RETRY)) begin
          w_state_next = GAP;
          w_retry_next = r_retry + 3'd1;
        end else begin
          w_state_next = FAIL;
        end
      end
      GAP: begin
        if (r_cnt == CW'(GAP_CYCLES - 1)) begin
          w_state_next = LOAD;
        end else begin
          w_state_next = GAP;
        end
      end
      DONE, FAIL: begin
        if (reconfig) begin
          w_state_next = PWR;
          w_idx_next   = 8'd0;
          w_retry_next = 3'd0;
          w_nack_next  = 1'b0;
        end else begin
          w_state_next = r_state;
        end
      end
      default: begin
        w_state_next = PWR;
        w_idx_next   = 8'd0;
        w_retry_next = 3'd0;
        w_nack_next  = 1'b0;
      end
    endcase
    // Elapsed-cycle counter restarts on every state entry.
    if (w_state_next != r_state) begin
      w_cnt_next = '0;
    end else begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  // State, bookkeeping and all outputs registered from the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= PWR;
      r_cnt      <= '0;
      r_idx      <= 8'd0;
      r_retry    <= 3'd0;
      r_nack     <= 1'b0;
      r_start    <= 1'b0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_reg_addr <= 8'd0;
      r_data     <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_retry <= w_retry_next;
      r_nack  <= w_nack_next;
      r_start <= (w_state_next == ISSUE);
      r_done  <= (w_state_next == DONE);
      r_error <= (w_state_next == FAIL);
      r_busy  <= !((w_state_next == DONE) || (w_state_next == FAIL));
      if (w_state_next == LOAD) begin
        r_reg_addr <= w_entry.reg_addr;
        r_data     <= w_entry.data;
      end else begin
        r_reg_addr <= r_reg_addr;
        r_data     <= r_data;
      end
    end
  end

  assign i2c_start    = r_start;
  assign i2c_dev_addr = DEV_ADDR;
  assign i2c_reg_addr = r_reg_addr;
  assign i2c_data     = r_data;
  assign cfg_busy     = r_busy;
  assign cfg_done     = r_done;
  assign cfg_error    = r_error;
  assign cfg_index    = r_idx;

endmodule
